sccb_cmd_queue: RTL and testbench

Host-side command front end for `sccb_ctrl`: buffers single-register read/write commands from a host (UART/CPU bridge) in a small FIFO and issues them one at a time over the `rreq`/`wreq` handshake once camera init is complete. Each command returns exactly one response carrying read data or a timeout error. Sits directly upstream of `sccb_ctrl` and drives its `addr_rw`, `data_write`, `rreq` and `wreq` inputs.

---
 rtl/sccb_pkg.sv | 29 ++
 rtl/sccb_cmd_fifo.sv | 53 +++++
 rtl/sccb_cmd_queue.sv | 156 +++++++++++++++
 tb/tb_sccb_cmd_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types for the SCCB host command path: the FSM state encoding and the
// 17-bit command word {we, addr, data} that any host bridge hands to the queue.
package sccb_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } sccb_state_e;

  localparam int CMD_W = 17;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_cmd_t;

  function automatic sccb_cmd_t pack_cmd(input logic we, input logic [7:0] addr,
                                         input logic [7:0] data);
    sccb_cmd_t c;
    c.we   = we;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

endpackage

// File: rtl/sccb_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head; push into a full
// FIFO or pop from an empty one is ignored.
module sccb_cmd_fifo
  import sccb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk25,
  input  logic      RESET,
  input  logic      i_push,
  input  sccb_cmd_t i_data,
  input  logic      i_pop,
  output sccb_cmd_t o_head,
  output logic      o_full,
  output logic      o_empty,
  output logic [AW:0] o_count
);

  sccb_cmd_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk25) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk25) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sccb_cmd_queue.sv
// Host command front end for sccb_ctrl: queues register read/write commands and
// issues them one at a time over rreq/wreq, returning one response per command.
module sccb_cmd_queue
  import sccb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GUARD   = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic       clk25,
  input  logic       RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_we,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  input  logic       init_done,
  input  logic       com_done,
  input  logic [7:0] data_read,
  output logic       rreq,
  output logic       wreq,
  output logic [7:0] addr_rw,
  output logic [7:0] data_write
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GUARD);
  localparam int TW = $clog2(TIMEOUT);
  // WAIT_DONE is entered so that com_done is first sampled GUARD edges after launch.
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 2);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT - 1);

  sccb_state_e   r_state, w_state_nxt;
  sccb_cmd_t     w_cmd_in, w_head;
  logic          w_full, w_empty, w_push, w_pop;
  logic [AW:0]   w_count, w_count_nxt;
  logic          w_launch, w_ok, w_abort, w_busy_nxt;

  logic [GW-1:0] r_guard;
  logic [TW-1:0] r_tmo;
  logic          r_we, r_rreq, r_wreq, r_busy;
  logic [7:0]    r_addr_rw, r_data_write;
  logic          r_rsp_valid, r_rsp_we, r_rsp_err;
  logic [7:0]    r_rsp_addr, r_rsp_rdata;

  assign w_cmd_in  = pack_cmd(cmd_we, cmd_addr, cmd_wdata);
  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & ~w_full;
  assign w_pop     = w_launch;

  sccb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk25   (clk25),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk25) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_ok        = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty && init_done) begin
        w_launch    = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (r_guard == GUARD_LAST) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (com_done) begin
          w_ok        = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (r_tmo == TMO_MAX) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      // Hold off until sccb_ctrl drops com_done so a stale done cannot end the next command.
      S_RELEASE: if (!com_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_busy_nxt  = (w_count_nxt != '0) || (w_state_nxt != S_IDLE);

  always_ff @(posedge clk25) begin
    if (RESET) begin
      r_guard      <= '0;
      r_tmo        <= '0;
      r_we         <= 1'b0;
      r_rreq       <= 1'b0;
      r_wreq       <= 1'b0;
      r_addr_rw    <= '0;
      r_data_write <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_we     <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_busy      <= w_busy_nxt;
      if (w_launch) begin
        r_addr_rw    <= w_head.addr;
        r_data_write <= w_head.data;
        r_we         <= w_head.we;
        r_rreq       <= ~w_head.we;
        r_wreq       <= w_head.we;
        r_guard      <= '0;
        r_tmo        <= '0;
      end else if (r_state == S_ISSUE || r_state == S_WAIT_DONE) begin
        if (r_state == S_ISSUE) r_guard <= r_guard + 1'b1;
        if (r_tmo != TMO_MAX)   r_tmo   <= r_tmo + 1'b1;
      end
      if (w_ok || w_abort) begin
        r_rreq      <= 1'b0;
        r_wreq      <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_we    <= r_we;
        r_rsp_addr  <= r_addr_rw;
        r_rsp_rdata <= (w_ok && !r_we) ? data_read : 8'h00;
        r_rsp_err   <= w_abort;
      end
    end
  end

  assign rreq       = r_rreq;
  assign wreq       = r_wreq;
  assign addr_rw    = r_addr_rw;
  assign data_write = r_data_write;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_we     = r_rsp_we;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sccb_cmd_queue.sv
// Directed bench for sccb_cmd_queue: a small sccb_ctrl responder model, request
// window and response monitors, and hand-computed expectations per scenario.
module tb_sccb_cmd_queue;

  logic       clk25 = 1'b0;
  logic       RESET = 1'b1;
  logic       cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       init_done = 1'b0;
  logic       com_done;
  logic [7:0] data_read;
  logic       cmd_ready, rsp_valid, rsp_we, rsp_err, busy, rreq, wreq;
  logic [7:0] rsp_addr, rsp_rdata, addr_rw, data_write;

  // Responder: manual drive, or auto com_done pulse auto_dly edges after request rise.
  logic       auto_en = 1'b0, auto_done = 1'b0, man_done = 1'b0;
  logic [7:0] auto_data = '0, man_data = '0;
  int         auto_dly = 8, age = 0;

  assign com_done  = auto_en ? auto_done : man_done;
  assign data_read = auto_en ? auto_data : man_data;

  always #20 clk25 = ~clk25;

  sccb_cmd_queue #(.DEPTH(4), .GUARD(4), .TIMEOUT(64)) dut (
    .clk25(clk25), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .init_done(init_done), .com_done(com_done), .data_read(data_read),
    .rreq(rreq), .wreq(wreq), .addr_rw(addr_rw), .data_write(data_write)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
    bit         stable;
    int         gap;
  } win_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  win_t wins[$];
  rsp_t rsps[$];
  win_t cur;
  bit   in_win = 0;
  int   low_cnt = 0, both_hi = 0, req_hi_cycles = 0;
  int   n_cmp = 0, n_err = 0;

  always @(negedge clk25) begin
    if (!auto_en) begin
      age = 0; auto_done = 1'b0;
    end else if (rreq || wreq) begin
      age++;
      auto_done = (age == auto_dly);
    end else begin
      age = 0; auto_done = 1'b0;
    end
  end

  always @(negedge clk25) begin
    if (rreq && wreq) both_hi++;
    if (rreq || wreq) begin
      req_hi_cycles++;
      if (!in_win) begin
        in_win = 1;
        cur.we = wreq; cur.addr = addr_rw; cur.data = data_write;
        cur.len = 0; cur.stable = 1; cur.gap = low_cnt;
      end
      cur.len++;
      if (addr_rw != cur.addr || data_write != cur.data || wreq != cur.we) cur.stable = 0;
    end else begin
      if (in_win) begin
        wins.push_back(cur);
        in_win = 0;
        low_cnt = 0;
      end
      low_cnt++;
    end
    if (rsp_valid) rsps.push_back('{rsp_we, rsp_addr, rsp_rdata, rsp_err});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    @(negedge clk25);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int n, input int budget, input string tag);
    int k = 0;
    while (rsps.size() < n && k < budget) begin
      @(negedge clk25);
      k++;
    end
    chk(tag, rsps.size(), n);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int k = 0;
    while (!(rreq || wreq) && k < budget) begin
      @(negedge clk25);
      k++;
    end
    chk(tag, 32'(rreq || wreq), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, acc, snap;
    logic [7:0] base;

    // Reset state
    tick(3);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req", {rreq, wreq}, 0);
    chk("rst_addr_data", {addr_rw, data_write}, 0);
    chk("rst_rsp", {rsp_valid, rsp_we, rsp_err, rsp_addr, rsp_rdata}, 0);
    chk("rst_busy", busy, 0);
    RESET = 1'b0;
    init_done = 1'b1;
    tick(2);

    // Single read: com_done sampled 20 edges after request rise
    push(1'b0, 8'h0A, 8'h00);
    chk("rd_lat_rreq_low", rreq, 0);
    chk("rd_busy", busy, 1);
    @(negedge clk25);
    chk("rd_rreq_rise", {rreq, wreq}, 2'b10);
    chk("rd_addr_rw", addr_rw, 8'h0A);
    cnt = 1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk25);
      if (rreq) cnt++;
    end
    man_done = 1'b1; man_data = 8'h76;
    @(negedge clk25);
    man_done = 1'b0;
    chk("rd_rreq_len", cnt, 20);
    chk("rd_rreq_drop", rreq, 0);
    chk("rd_rsp", {rsp_valid, rsp_we, rsp_err}, 3'b100);
    chk("rd_rsp_addr", rsp_addr, 8'h0A);
    chk("rd_rsp_rdata", rsp_rdata, 8'h76);
    @(negedge clk25);
    chk("rd_rsp_pulse", rsp_valid, 0);
    chk("rd_busy_idle", busy, 0);
    tick(2);

    // Back-to-back writes with auto responder
    rsps.delete(); wins.delete();
    auto_en = 1'b1; auto_dly = 8; auto_data = 8'h55;
    push(1'b1, 8'h12, 8'h80);
    push(1'b1, 8'h11, 8'h01);
    wait_rsps(2, 100, "wr_rsp_count");
    tick(3);
    chk("wr_win_count", wins.size(), 2);
    if (wins.size() == 2 && rsps.size() == 2) begin
      chk("wr0_win", {wins[0].we, wins[0].addr, wins[0].data}, {1'b1, 8'h12, 8'h80});
      chk("wr1_win", {wins[1].we, wins[1].addr, wins[1].data}, {1'b1, 8'h11, 8'h01});
      chk("wr_stable", {wins[0].stable, wins[1].stable}, 2'b11);
      chk("wr0_len", wins[0].len, 8);
      chk("wr_gap", 32'(wins[1].gap >= 1), 1);
      chk("wr0_rsp", {rsps[0].we, rsps[0].addr, rsps[0].rdata, rsps[0].err}, {1'b1, 8'h12, 8'h00, 1'b0});
      chk("wr1_rsp", {rsps[1].we, rsps[1].addr, rsps[1].rdata, rsps[1].err}, {1'b1, 8'h11, 8'h00, 1'b0});
    end

    // init_done low: fill FIFO, fifth command refused, nothing launches
    rsps.delete(); wins.delete();
    init_done = 1'b0; auto_dly = 6; auto_data = 8'h3C;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      base = 8'h20 + 8'(i);
      cmd_valid = 1'b1; cmd_we = i[0]; cmd_addr = base; cmd_wdata = base + 8'h40;
      if (cmd_ready) acc++;
      @(negedge clk25);
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", acc, 4);
    chk("fill_ready_low", cmd_ready, 0);
    tick(10);
    chk("fill_no_req", wins.size() + 32'(rreq || wreq), 0);
    chk("fill_busy", busy, 1);
    init_done = 1'b1;
    wait_rsps(4, 200, "fill_rsp_count");
    if (rsps.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        base = 8'h20 + 8'(i);
        chk($sformatf("fill_rsp%0d", i), {rsps[i].we, rsps[i].addr, rsps[i].rdata, rsps[i].err},
            {i[0], base, i[0] ? 8'h00 : 8'h3C, 1'b0});
      end
    end
    tick(4);
    chk("fill_win_count", wins.size(), 4);
    chk("fill_empty", {busy, cmd_ready}, 2'b01);

    // Stale com_done high during guard must be ignored
    rsps.delete(); wins.delete();
    auto_en = 1'b0; man_data = 8'h99;
    push(1'b0, 8'h33, 8'h00);
    @(negedge clk25);
    chk("stale_rreq", rreq, 1);
    man_done = 1'b1;
    tick(3);
    man_done = 1'b0;
    tick(2);
    chk("stale_ignored", {rreq, 32'(rsps.size())}, {1'b1, 32'd0});
    tick(4);
    man_done = 1'b1;
    @(negedge clk25);
    man_done = 1'b0;
    chk("stale_drop", rreq, 0);
    chk("stale_rsp", {rsp_valid, rsp_err, rsp_addr, rsp_rdata}, {1'b1, 1'b0, 8'h33, 8'h99});
    tick(3);
    chk("stale_one_rsp", rsps.size(), 1);

    // Timeout: com_done never comes
    rsps.delete(); wins.delete();
    man_data = 8'hEE;
    push(1'b1, 8'h44, 8'hAA);
    push(1'b0, 8'h45, 8'h00);
    wait_rsps(2, 300, "to_rsp_count");
    tick(3);
    if (rsps.size() == 2 && wins.size() == 2) begin
      chk("to0_rsp", {rsps[0].we, rsps[0].addr, rsps[0].rdata, rsps[0].err}, {1'b1, 8'h44, 8'h00, 1'b1});
      chk("to1_rsp", {rsps[1].we, rsps[1].addr, rsps[1].rdata, rsps[1].err}, {1'b0, 8'h45, 8'h00, 1'b1});
      chk("to0_len", wins[0].len, 64);
      chk("to1_len", wins[1].len, 64);
    end

    // Reset in WAIT_DONE with two commands queued
    rsps.delete(); wins.delete();
    push(1'b0, 8'h50, 8'h00);
    push(1'b0, 8'h51, 8'h00);
    push(1'b0, 8'h52, 8'h00);
    wait_req(10, "rst_mid_launch");
    tick(8);
    chk("rst_mid_busy_before", busy, 1);
    RESET = 1'b1;
    @(negedge clk25);
    RESET = 1'b0;
    chk("rst_mid_req", {rreq, wreq}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    snap = req_hi_cycles;
    tick(20);
    chk("rst_mid_no_relaunch", req_hi_cycles - snap, 0);
    chk("rst_mid_no_rsp", rsps.size(), 0);

    chk("never_both_req", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
